// File: rtl/block_draw_ctrl.sv
// block_draw_ctrl: sequences a 4x4 block draw (optionally erasing the previous block first).
// Ports: clk/resetn; req_valid/req_ready/req_x/req_y/req_colour request side;
// dp_x/dp_y/dp_colour/dp_count_en/dp_done datapath side; plot, busy, draw_done status.
// Optional feature: define BLOCK_DRAW_ERASE_EN to repaint the previous block in BG_COLOUR.
module block_draw_ctrl #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter logic [7:0] X_MAX     = 8'd156
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic [7:0] dp_x,
    output logic [6:0] dp_y,
    output logic [2:0] dp_colour,
    output logic       dp_count_en,
    input  logic       dp_done,
    output logic       plot,
    output logic       busy,
    output logic       draw_done
);

    typedef enum logic [1:0] {
        IDLE,
`ifdef BLOCK_DRAW_ERASE_EN
        ERASE,
`endif
        DRAW,
        FINISH
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [2:0] cur_colour;
    logic [7:0] x_clamped;
    logic       accept;

    assign x_clamped = (req_x > X_MAX) ? X_MAX : req_x;
    assign accept    = (state == IDLE) && req_valid;

`ifdef BLOCK_DRAW_ERASE_EN
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic       prev_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else if (state == DRAW && dp_done) begin
            prev_x     <= cur_x;
            prev_y     <= cur_y;
            prev_valid <= 1'b1;
        end
    end
`else
    logic unused_bg;
    assign unused_bg = ^BG_COLOUR;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_colour <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur_x      <= x_clamped;
                cur_y      <= req_y;
                cur_colour <= req_colour;
            end
        end
    end

    // dp_* follow the latched request except during erase; the latch only
    // updates on the accepting edge, so IDLE/FINISH hold the last drawn values.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        plot        = 1'b0;
        dp_count_en = 1'b0;
        busy        = 1'b1;
        draw_done   = 1'b0;
        dp_x        = cur_x;
        dp_y        = cur_y;
        dp_colour   = cur_colour;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
`ifdef BLOCK_DRAW_ERASE_EN
                    state_nxt = prev_valid ? ERASE : DRAW;
`else
                    state_nxt = DRAW;
`endif
                end
            end
`ifdef BLOCK_DRAW_ERASE_EN
            ERASE: begin
                dp_x        = prev_x;
                dp_y        = prev_y;
                dp_colour   = BG_COLOUR;
                plot        = 1'b1;
                dp_count_en = 1'b1;
                if (dp_done) state_nxt = DRAW;
            end
`endif
            DRAW: begin
                plot        = 1'b1;
                dp_count_en = 1'b1;
                if (dp_done) state_nxt = FINISH;
            end
            FINISH: begin
                draw_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_draw_ctrl.sv
// tb_block_draw_ctrl: directed bench for block_draw_ctrl with a 4x4 pixel counter model.
// Follows BLOCK_DRAW_ERASE_EN so it expects erase passes when that macro is set.
module tb_block_draw_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [7:0] dp_x;
    logic [6:0] dp_y;
    logic [2:0] dp_colour;
    logic       dp_count_en;
    logic       dp_done;
    logic       plot;
    logic       busy;
    logic       draw_done;

    logic [3:0] pix;
    logic       force_done;
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         have_prev;
    logic [7:0] px;
    logic [6:0] py;

    always #5 clk = ~clk;

    block_draw_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .dp_colour  (dp_colour),
        .dp_count_en(dp_count_en),
        .dp_done    (dp_done),
        .plot       (plot),
        .busy       (busy),
        .draw_done  (draw_done)
    );

    always @(posedge clk or negedge resetn) begin
        if (!resetn) pix <= '0;
        else if (dp_count_en) pix <= pix + 4'd1;
    end

    assign dp_done = (pix == 4'd15) || force_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_draw(input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic [7:0] ex,
                           input bit hold);
        req_x      = x;
        req_y      = y;
        req_colour = c;
        req_valid  = 1'b1;
        chk("accept_ready", req_ready, 1);
        chk("accept_busy", busy, 0);
        step();
        if (hold) req_x = x ^ 8'h01;
        else req_valid = 1'b0;
`ifdef BLOCK_DRAW_ERASE_EN
        if (have_prev) begin
            for (int i = 0; i < 16; i++) begin
                chk("erase_plot", plot, 1);
                chk("erase_cnt_en", dp_count_en, 1);
                chk("erase_x", dp_x, px);
                chk("erase_y", dp_y, py);
                chk("erase_colour", dp_colour, 0);
                chk("erase_pix", pix, i);
                chk("erase_ready", req_ready, 0);
                step();
            end
        end
`endif
        for (int i = 0; i < 16; i++) begin
            chk("draw_plot", plot, 1);
            chk("draw_cnt_en", dp_count_en, 1);
            chk("draw_x", dp_x, ex);
            chk("draw_y", dp_y, y);
            chk("draw_colour", dp_colour, c);
            chk("draw_pix", pix, i);
            chk("draw_busy", busy, 1);
            chk("draw_ready", req_ready, 0);
            chk("draw_done_low", draw_done, 0);
            step();
        end
        chk("fin_done", draw_done, 1);
        chk("fin_ready", req_ready, 0);
        chk("fin_plot", plot, 0);
        chk("fin_busy", busy, 1);
        chk("fin_hold_x", dp_x, ex);
        chk("fin_pix", pix, 0);
        step();
        chk("idle_done", draw_done, 0);
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_plot", plot, 0);
        chk("idle_hold_x", dp_x, ex);
        chk("idle_hold_y", dp_y, y);
        chk("idle_hold_c", dp_colour, c);
        have_prev = 1'b1;
        px        = ex;
        py        = y;
    endtask

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        force_done = 1'b0;
        have_prev  = 1'b0;
        px         = '0;
        py         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_plot", plot, 0);
        chk("rst_cnt_en", dp_count_en, 0);
        chk("rst_done", draw_done, 0);
        chk("rst_x", dp_x, 0);
        chk("rst_y", dp_y, 0);
        chk("rst_colour", dp_colour, 0);
        resetn = 1'b1;

        // abort a draw at pixel 7 with reset
        req_x      = 8'd50;
        req_y      = 7'd30;
        req_colour = 3'd2;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("abort_pre_plot", plot, 1);
            step();
        end
        chk("abort_pix7", pix, 7);
        chk("abort_x", dp_x, 50);
        resetn = 1'b0;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_cnt_en", dp_count_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_pix", pix, 0);
        chk("abort_x_clr", dp_x, 0);
        #2;
        resetn = 1'b1;
        step();
        chk("post_abort_plot", plot, 0);
        chk("post_abort_busy", busy, 0);

        do_draw(8'd10, 7'd20, 3'b100, 8'd10, 1'b0);
        do_draw(8'd10, 7'd24, 3'd5, 8'd10, 1'b1);
        chk("hold_valid_ready", req_ready, 1);
        do_draw(8'd200, 7'd24, 3'd3, 8'd156, 1'b0);

        // dp_done asserted while idle must do nothing
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("idle_force_busy", busy, 0);
            chk("idle_force_plot", plot, 0);
            chk("idle_force_ready", req_ready, 1);
            step();
        end
        force_done = 1'b0;

        do_draw(8'd156, 7'd127, 3'd7, 8'd156, 1'b0);
        do_draw(8'd157, 7'd0, 3'd1, 8'd156, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/block_draw_ctrl.md
BLOCK_DRAW_CTRL -- requirements
Module: block_draw_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-002 Parameter BG_COLOUR, default 3'b000, SHALL be the colour used when erasing a block.
REQ-003 Parameter X_MAX, default 8'd156, SHALL be the largest legal block origin x; larger requests clamp to it.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port req_valid, input, 1 bit: a draw request is present.
REQ-007 Port req_ready, output, 1 bit: the block can accept a request.
REQ-008 Port req_x, input, 8 bits: block origin x.
REQ-009 Port req_y, input, 7 bits: block origin y.
REQ-010 Port req_colour, input, 3 bits: block colour.
REQ-011 Port dp_x, output, 8 bits: origin x to the 4x4 pixel datapath.
REQ-012 Port dp_y, output, 7 bits: origin y to the datapath.
REQ-013 Port dp_colour, output, 3 bits: colour to the datapath.
REQ-014 Port dp_count_en, output, 1 bit: advances the datapath pixel counter.
REQ-015 Port dp_done, input, 1 bit: the datapath is presenting pixel (3,3), the last of 16.
REQ-016 Port plot, output, 1 bit: VGA write enable.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port draw_done, output, 1 bit: one-cycle pulse when a request completes.

Function
REQ-019 The state machine SHALL have states IDLE, ERASE, DRAW and FINISH, with ERASE present only under the configuration macro.
REQ-020 IDLE: req_ready=1, plot=0, dp_count_en=0; on req_valid, latch x (clamped to X_MAX), y and colour.
REQ-021 On acceptance in IDLE, the next state SHALL be ERASE if the macro is set and prev_valid=1, and DRAW otherwise.
REQ-022 ERASE: drive dp_x=prev_x, dp_y=prev_y, dp_colour=BG_COLOUR, dp_count_en=1, plot=1; on dp_done, go to DRAW.
REQ-023 DRAW: drive the latched x, y and colour with dp_count_en=1 and plot=1; on dp_done, load prev_x/prev_y from the latched values, set prev_valid=1, and go to FINISH.
REQ-024 FINISH: draw_done=1 for one cycle, req_ready=0, then go to IDLE.
REQ-025 Latency without erase: accept at cycle 0, plot during cycles 1-16, draw_done at cycle 17, req_ready=1 at cycle 18.
REQ-026 Latency with erase: plot during cycles 1-32, draw_done at cycle 33.
REQ-027 dp_done SHALL be ignored in IDLE and FINISH.
REQ-028 req_valid SHALL be ignored while req_ready=0, including a request coinciding with draw_done.
REQ-029 In IDLE and FINISH, dp_x, dp_y and dp_colour SHALL hold their last driven values.
REQ-030 Each plotting phase SHALL last exactly 16 dp_count_en cycles, so the datapath's 2-bit counters wrap to (0,0) at the end of the phase.
REQ-031 req_x > X_MAX SHALL be clamped to X_MAX; req_y SHALL not be clamped.

Reset
REQ-032 While resetn=0: state IDLE; latched and prev registers 0; prev_valid=0; plot=0, dp_count_en=0, draw_done=0, busy=0, req_ready=1.
REQ-033 Reset asserted mid-ERASE or mid-DRAW SHALL abort the operation immediately with no further plot pulses; the datapath counter shares resetn and so stays aligned.

Configuration
REQ-034 With macro BLOCK_DRAW_ERASE_EN defined, the ERASE state and the prev_x/prev_y/prev_valid registers SHALL exist, and each draw after the first SHALL first repaint the previous block in BG_COLOUR.
REQ-035 With BLOCK_DRAW_ERASE_EN undefined, ERASE, prev_x, prev_y and prev_valid SHALL be absent, and every request SHALL go IDLE->DRAW->FINISH.

Verification
REQ-036 After reset, req (x=10, y=20, colour=3'b100) -> 16 plot cycles at dp_x=10, dp_y=20, dp_colour=4; draw_done at cycle 17.
REQ-037 req_valid held high throughout a draw -> exactly one acceptance per IDLE visit; a second draw starts at cycle 18.
REQ-038 req_x=200 -> dp_x=156 for the whole draw.
REQ-039 With ERASE_EN: req (10,20), then req (10,24) -> 16 plots at (10,20) with colour 0, then 16 plots at (10,24); draw_done at cycle 33.
REQ-040 resetn pulsed low at DRAW pixel 7 -> plot drops immediately; the next request yields a full 16-pixel draw starting at pixel (0,0).
REQ-041 dp_done forced high in IDLE -> no state change and no plot.
